// File: rtl/cipher_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cipher_arbiter
// Description : Round-robin arbiter and sequencer that shares one 128-bit
//               block-cipher core between two requesters. Grants one job at
//               a time, drives the core start/operand interface, waits for
//               completion under a watchdog and returns the result (done)
//               or a timeout (err) to the owning requester.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   req0/req1            job request, held high until the matching ack
//   text0/1, key0/1      job operands, valid while req is high
//   ack0/ack1            one-cycle pulse: job accepted (START cycle)
//   done0/done1          one-cycle pulse: result valid for that requester
//   err0/err1            one-cycle pulse: job timed out, result forced to 0
//   result               job result, valid with a done pulse
//   busy                 high whenever the sequencer is not idle
//   core_start           one-cycle start pulse to the core
//   core_text/core_key   operand registers, stable for the whole job
//   core_done            core completion strobe (only honoured while waiting)
//   core_result          core output, valid with core_done
// ============================================================================
module cipher_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [127:0] text0,
  input  logic [127:0] text1,
  input  logic [127:0] key0,
  input  logic [127:0] key1,
  output logic         ack0,
  output logic         ack1,
  output logic         done0,
  output logic         done1,
  output logic         err0,
  output logic         err1,
  output logic [127:0] result,
  output logic         busy,
  output logic         core_start,
  output logic [127:0] core_text,
  output logic [127:0] core_key,
  input  logic         core_done,
  input  logic [127:0] core_result
);

  localparam int c_cnt_w = $clog2(TIMEOUT) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t               r_state, w_state;
  logic                 r_owner, w_owner;
  logic                 r_prio, w_prio;
  logic [c_cnt_w-1:0]   r_cnt, w_cnt;
  logic [127:0]         r_text, w_text;
  logic [127:0]         r_key, w_key;
  logic [127:0]         r_result, w_result;
  logic [1:0]           r_ack, w_ack;
  logic [1:0]           r_done, w_done;
  logic [1:0]           r_err, w_err;
  logic                 r_core_start, w_core_start;
  logic                 w_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_prio       <= 1'b0;
      r_cnt        <= '0;
      r_text       <= '0;
      r_key        <= '0;
      r_result     <= '0;
      r_ack        <= '0;
      r_done       <= '0;
      r_err        <= '0;
      r_core_start <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_owner      <= w_owner;
      r_prio       <= w_prio;
      r_cnt        <= w_cnt;
      r_text       <= w_text;
      r_key        <= w_key;
      r_result     <= w_result;
      r_ack        <= w_ack;
      r_done       <= w_done;
      r_err        <= w_err;
      r_core_start <= w_core_start;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_owner      = r_owner;
    w_prio       = r_prio;
    w_cnt        = r_cnt;
    w_text       = r_text;
    w_key        = r_key;
    w_result     = r_result;
    w_ack        = 2'b00;
    w_done       = 2'b00;
    w_err        = 2'b00;
    w_core_start = 1'b0;
    // Sole requester wins outright; a tie goes to the favoured requester.
    w_grant      = (req0 && req1) ? r_prio : req1;

    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          w_state      = ST_START;
          w_owner      = w_grant;
          w_text       = w_grant ? text1 : text0;
          w_key        = w_grant ? key1 : key0;
          // ack and core_start are registered so they appear in the START cycle.
          w_ack        = w_grant ? 2'b10 : 2'b01;
          w_core_start = 1'b1;
        end
      end
      ST_START: begin
        w_cnt   = '0;
        w_prio  = ~r_prio;
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion takes precedence over a watchdog expiry in the same cycle.
        if (core_done) begin
          w_result = core_result;
          w_done   = r_owner ? 2'b10 : 2'b01;
          w_state  = ST_IDLE;
        end else if (r_cnt == c_cnt_last) begin
          w_result = '0;
          w_err    = r_owner ? 2'b10 : 2'b01;
          w_state  = ST_IDLE;
        end else begin
          w_cnt = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign ack0       = r_ack[0];
  assign ack1       = r_ack[1];
  assign done0      = r_done[0];
  assign done1      = r_done[1];
  assign err0       = r_err[0];
  assign err1       = r_err[1];
  assign result     = r_result;
  assign busy       = (r_state != ST_IDLE);
  assign core_start = r_core_start;
  assign core_text  = r_text;
  assign core_key   = r_key;

endmodule
`default_nettype wire

// File: tb/tb_cipher_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cipher_arbiter
// Description : Scoreboard bench for cipher_arbiter. Directed jobs push their
//               expected ack/done/err events into a queue; a negedge monitor
//               pops and compares whenever the DUT pulses. A small core model
//               answers core_start after a programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cipher_arbiter;

  localparam int TIMEOUT = 64;

  localparam logic [5:0] P_ACK0  = 6'b000001;
  localparam logic [5:0] P_ACK1  = 6'b000010;
  localparam logic [5:0] P_DONE0 = 6'b000100;
  localparam logic [5:0] P_DONE1 = 6'b001000;
  localparam logic [5:0] P_ERR1  = 6'b100000;

  localparam logic [127:0] T1   = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] K1   = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] RES1 = 128'hdeadbeef0123456789abcdefcafef00d;
  localparam logic [127:0] T0A  = 128'h000000000000000000000000000000a0;
  localparam logic [127:0] K0A  = 128'h111111111111111122222222222222a0;
  localparam logic [127:0] T0B  = 128'h000000000000000000000000000000b0;
  localparam logic [127:0] K0B  = 128'h333333333333333344444444444444b0;
  localparam logic [127:0] T1A  = 128'h100000000000000000000000000000a1;
  localparam logic [127:0] K1A  = 128'h555555555555555566666666666666a1;
  localparam logic [127:0] T1B  = 128'h100000000000000000000000000000b1;
  localparam logic [127:0] K1B  = 128'h777777777777777788888888888888b1;
  localparam logic [127:0] T3   = 128'hfedcba9876543210fedcba9876543210;
  localparam logic [127:0] K3   = 128'h0badc0de0badc0de0badc0de0badc0de;
  localparam logic [127:0] T4   = 128'h13579bdf2468ace013579bdf2468ace0;
  localparam logic [127:0] K4   = 128'hc001d00dc001d00dc001d00dc001d00d;
  localparam logic [127:0] T5   = 128'h55555555aaaaaaaa55555555aaaaaaaa;
  localparam logic [127:0] K5   = 128'h99999999999999990000000000000005;
  localparam logic [127:0] T6   = 128'h66666666666666666666666666666666;
  localparam logic [127:0] K6   = 128'h0000000000000006ffffffffffffffff;
  localparam logic [127:0] T7   = 128'h77777777777777777777777777777777;
  localparam logic [127:0] K7   = 128'h0000000000000007eeeeeeeeeeeeeeee;
  localparam logic [127:0] SPUR = 128'h11112222333344445555666677778888;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_a [2];
  logic [127:0] text_a [2];
  logic [127:0] key_a [2];
  logic         ack0, ack1, done0, done1, err0, err1, busy, core_start, core_done;
  logic [127:0] result, core_text, core_key, core_result;
  logic [1:0]   ack_v;

  typedef struct {
    logic [5:0]   pulses;
    int           cyc;
    logic [127:0] d0;
    logic [127:0] d1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  logic [127:0] job_text [2][16];
  logic [127:0] job_key  [2][16];
  int           job_cnt  [2] = '{0, 0};
  int           job_idx  [2] = '{0, 0};

  int           core_lat   = -1;
  bit           core_fixed = 1'b0;
  logic [127:0] fixed_val  = '0;
  int           spur_due   = -1;
  int           core_due   = -1;
  logic [127:0] core_res_hold = '0;

  cipher_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req_a[0]),
    .req1        (req_a[1]),
    .text0       (text_a[0]),
    .text1       (text_a[1]),
    .key0        (key_a[0]),
    .key1        (key_a[1]),
    .ack0        (ack0),
    .ack1        (ack1),
    .done0       (done0),
    .done1       (done1),
    .err0        (err0),
    .err1        (err1),
    .result      (result),
    .busy        (busy),
    .core_start  (core_start),
    .core_text   (core_text),
    .core_key    (core_key),
    .core_done   (core_done),
    .core_result (core_result)
  );

  assign ack_v = {ack1, ack0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k);
    return t ^ {k[63:0], k[127:64]} ^ 128'ha5a5a5a5c3c3c3c35a5a5a5a3c3c3c3c;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input logic [5:0] p, input int c, input logic [127:0] a,
                           input logic [127:0] b);
    exp_t e;
    e.pulses = p;
    e.cyc    = c;
    e.d0     = a;
    e.d1     = b;
    exp_q.push_back(e);
  endtask

  task automatic add_job(input int id, input logic [127:0] t, input logic [127:0] k);
    job_text[id][job_cnt[id]] = t;
    job_key[id][job_cnt[id]]  = k;
    job_cnt[id]++;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    chk("events_outstanding", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_core_start", 128'(core_start), 128'd0);
    chk("rst_core_text", core_text, 128'd0);
    chk("rst_core_key", core_key, 128'd0);
    chk("rst_result", result, 128'd0);
    chk("rst_pulses", 128'({err1, err0, done1, done0, ack1, ack0}), 128'd0);
  endtask

  // Requesters: raise a queued job when idle, drop req in the ack cycle.
  initial begin
    for (int i = 0; i < 2; i++) begin
      req_a[i]  = 1'b0;
      text_a[i] = '0;
      key_a[i]  = '0;
    end
    forever begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
        if (req_a[id] && ack_v[id]) begin
          req_a[id] = 1'b0;
          job_idx[id]++;
        end else if (!req_a[id] && job_idx[id] < job_cnt[id]) begin
          text_a[id] = job_text[id][job_idx[id]];
          key_a[id]  = job_key[id][job_idx[id]];
          req_a[id]  = 1'b1;
        end
      end
    end
  end

  // Core model: answers core_start after core_lat cycles; noise on the bus otherwise.
  initial begin
    bit rs;
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk);
      rs = reset;
      #1;
      if (rs) core_due = -1;
      if (core_start) begin
        core_due      = (core_lat >= 0) ? cyc + core_lat : -1;
        core_res_hold = core_fixed ? fixed_val : core_fn(core_text, core_key);
      end
      core_done = (cyc == core_due) || (cyc == spur_due);
      if (cyc == core_due)      core_result = core_res_hold;
      else if (cyc == spur_due) core_result = SPUR;
      else                      core_result = {4{$urandom()}};
    end
  end

  // Monitor: every pulse must match the head of the expected-event queue.
  always @(negedge clk) begin : mon
    logic [5:0] p;
    exp_t       e;
    p = {err1, err0, done1, done0, ack1, ack0};
    if (core_start || ack0 || ack1)
      chk("core_start_with_ack", 128'(core_start), 128'(ack0 | ack1));
    if (p != 6'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_pulse: got pulses %b, expected none (cycle %0d)", p, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 128'(p), 128'(e.pulses));
        chk("pulse_cycle", 128'(cyc), 128'(e.cyc));
        if (e.pulses[1:0] != 2'b00) begin
          chk("core_text", core_text, e.d0);
          chk("core_key", core_key, e.d1);
          chk("busy_at_ack", 128'(busy), 128'd1);
        end else begin
          chk("result", result, e.d0);
          chk("busy_at_end", 128'(busy), 128'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int s;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // Single job on requester 0, core answers 30 cycles after start.
    @(posedge clk);
    #1;
    s          = cyc + 1;
    core_fixed = 1'b1;
    fixed_val  = RES1;
    core_lat   = 30;
    expect_ev(P_ACK0, s, T1, K1);
    expect_ev(P_DONE0, s + 31, RES1, '0);
    add_job(0, T1, K1);
    wait_drain(100);

    // Both requesters continuously busy after reset: grants 0,1,0,1.
    pulse_reset();
    core_fixed = 1'b0;
    core_lat   = 5;
    s          = cyc + 1;
    expect_ev(P_ACK0,  s,      T0A, K0A);
    expect_ev(P_DONE0, s + 6,  core_fn(T0A, K0A), '0);
    expect_ev(P_ACK1,  s + 7,  T1A, K1A);
    expect_ev(P_DONE1, s + 13, core_fn(T1A, K1A), '0);
    expect_ev(P_ACK0,  s + 14, T0B, K0B);
    expect_ev(P_DONE0, s + 20, core_fn(T0B, K0B), '0);
    expect_ev(P_ACK1,  s + 21, T1B, K1B);
    expect_ev(P_DONE1, s + 27, core_fn(T1B, K1B), '0);
    add_job(0, T0A, K0A);
    add_job(0, T0B, K0B);
    add_job(1, T1A, K1A);
    add_job(1, T1B, K1B);
    wait_drain(100);

    // Watchdog expiry on requester 1: err at S+65 with result cleared.
    core_lat = -1;
    s        = cyc + 1;
    expect_ev(P_ACK1, s, T3, K3);
    expect_ev(P_ERR1, s + 65, '0, '0);
    add_job(1, T3, K3);
    while (cyc < s + 64) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("busy_last_wait", 128'(busy), 128'd1);
    wait_drain(100);

    // core_done in the same cycle as the last watchdog count: done wins.
    core_lat = 64;
    s        = cyc + 1;
    expect_ev(P_ACK0, s, T4, K4);
    expect_ev(P_DONE0, s + 65, core_fn(T4, K4), '0);
    add_job(0, T4, K4);
    wait_drain(150);

    // Spurious core_done while idle: no pulse, result untouched.
    spur_due = cyc + 1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("spurious_result_held", result, core_fn(T4, K4));
    chk("spurious_busy", 128'(busy), 128'd0);
    spur_due = -1;

    // Reset asserted in the tenth WAIT cycle aborts the job silently.
    @(posedge clk);
    #1;
    core_lat = 30;
    s        = cyc + 1;
    expect_ev(P_ACK0, s, T5, K5);
    add_job(0, T5, K5);
    while (cyc != s + 10) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    chk("ack_before_reset", 128'(exp_q.size()), 128'd0);
    repeat (40) @(posedge clk);
    #1;

    // After the abort, priority is back to requester 0 on a tie.
    core_lat = 3;
    s        = cyc + 1;
    expect_ev(P_ACK0,  s,     T6, K6);
    expect_ev(P_DONE0, s + 4, core_fn(T6, K6), '0);
    expect_ev(P_ACK1,  s + 5, T7, K7);
    expect_ev(P_DONE1, s + 9, core_fn(T7, K7), '0);
    add_job(0, T6, K6);
    add_job(1, T7, K7);
    wait_drain(100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
